// File: rtl/axil_cpu_router.sv
// Routes one PS AXI4-Lite master to NS register slaves with address decode,
// a single transaction in flight, alternating read/write priority and a hang timeout.
module axil_cpu_router #(
  parameter int NS = 4,
  parameter int AW = 40,
  parameter int DW = 32,
  parameter logic [NS*AW-1:0] BASE = {40'h00_A000_3000, 40'h00_A000_2000,
                                      40'h00_A000_1000, 40'h00_A000_0000},
  parameter logic [NS*AW-1:0] MASK = {NS{40'hFF_FFFF_F000}},
  parameter int TIMEOUT = 255
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [AW-1:0]     s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DW-1:0]     s_axi_wdata,
  input  logic [DW/8-1:0]   s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [AW-1:0]     s_axi_araddr,
  input  logic [2:0]        s_axi_arprot,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DW-1:0]     s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [AW-1:0]     m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic [NS-1:0]     m_axi_awvalid,
  input  logic [NS-1:0]     m_axi_awready,
  output logic [DW-1:0]     m_axi_wdata,
  output logic [DW/8-1:0]   m_axi_wstrb,
  output logic [NS-1:0]     m_axi_wvalid,
  input  logic [NS-1:0]     m_axi_wready,
  input  logic [2*NS-1:0]   m_axi_bresp,
  input  logic [NS-1:0]     m_axi_bvalid,
  output logic [NS-1:0]     m_axi_bready,
  output logic [AW-1:0]     m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic [NS-1:0]     m_axi_arvalid,
  input  logic [NS-1:0]     m_axi_arready,
  input  logic [NS*DW-1:0]  m_axi_rdata,
  input  logic [2*NS-1:0]   m_axi_rresp,
  input  logic [NS-1:0]     m_axi_rvalid,
  output logic [NS-1:0]     m_axi_rready,
  output logic [2:0]        dbg_state
);
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  typedef enum logic [2:0] {IDLE = 3'd0, W_FWD, W_RESP, R_FWD, R_RESP, RESP} state_t;

  state_t          state;
  logic            prio_rd, is_wr;
  logic [TW-1:0]   timer;
  logic [SW-1:0]   sel_q, hit_idx;
  logic            hit, wr_cand, rd_cand, tmo, progress, busy, aw_left, w_left;
  logic [AW-1:0]   dec_addr;
  logic [1:0]      sel_bresp, sel_rresp, resp_q;
  logic [DW-1:0]   sel_rdata, rdata_q;
  logic            awready_q, wready_q, arready_q, bvalid_q, rvalid_q;

  assign wr_cand  = s_axi_awvalid & s_axi_wvalid;
  assign rd_cand  = s_axi_arvalid;
  assign dec_addr = awready_q ? s_axi_awaddr : s_axi_araddr;
  assign tmo      = (timer == TW'(TIMEOUT));
  assign aw_left  = |(m_axi_awvalid & ~m_axi_awready);
  assign w_left   = |(m_axi_wvalid & ~m_axi_wready);
  assign busy     = (state == W_FWD) || (state == W_RESP) || (state == R_FWD) || (state == R_RESP);

  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if ((dec_addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
        hit = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  always_comb begin
    sel_bresp = '0;
    sel_rresp = '0;
    sel_rdata = '0;
    for (int i = 0; i < NS; i++) begin
      if (sel_q == SW'(i)) begin
        sel_bresp = m_axi_bresp[2*i +: 2];
        sel_rresp = m_axi_rresp[2*i +: 2];
        sel_rdata = m_axi_rdata[i*DW +: DW];
      end
    end
  end

  // Only the selected slave ever has valid/ready set, so OR-reductions are per-slave.
  always_comb begin
    progress = 1'b0;
    case (state)
      W_FWD:   progress = !aw_left && !w_left;
      W_RESP:  progress = |(m_axi_bvalid & m_axi_bready);
      R_FWD:   progress = |(m_axi_arready & m_axi_arvalid);
      R_RESP:  progress = |(m_axi_rvalid & m_axi_rready);
      default: progress = 1'b0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;  prio_rd <= 1'b0;  is_wr <= 1'b0;  timer <= '0;  sel_q <= '0;
      awready_q <= 1'b0;  wready_q <= 1'b0;  arready_q <= 1'b0;
      bvalid_q <= 1'b0;  rvalid_q <= 1'b0;  resp_q <= '0;  rdata_q <= '0;
      m_axi_awaddr <= '0;  m_axi_awprot <= '0;  m_axi_wdata <= '0;  m_axi_wstrb <= '0;
      m_axi_araddr <= '0;  m_axi_arprot <= '0;
      m_axi_awvalid <= '0;  m_axi_wvalid <= '0;  m_axi_bready <= '0;
      m_axi_arvalid <= '0;  m_axi_rready <= '0;
    end else begin
      if (busy) timer <= timer + 1'b1;
      case (state)
        IDLE: begin
          if (awready_q || arready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            is_wr     <= awready_q;
            sel_q     <= hit_idx;
            if (awready_q) begin
              m_axi_awaddr <= s_axi_awaddr;
              m_axi_awprot <= s_axi_awprot;
              m_axi_wdata  <= s_axi_wdata;
              m_axi_wstrb  <= s_axi_wstrb;
            end else begin
              m_axi_araddr <= s_axi_araddr;
              m_axi_arprot <= s_axi_arprot;
            end
            if (!hit) begin
              resp_q   <= 2'b11;
              rdata_q  <= '0;
              bvalid_q <= awready_q;
              rvalid_q <= !awready_q;
              state    <= RESP;
            end else if (awready_q) begin
              m_axi_awvalid[hit_idx] <= 1'b1;
              m_axi_wvalid[hit_idx]  <= 1'b1;
              state <= W_FWD;
            end else begin
              m_axi_arvalid[hit_idx] <= 1'b1;
              state <= R_FWD;
            end
          end else if (wr_cand && (!rd_cand || !prio_rd)) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            prio_rd   <= ~prio_rd;
            timer     <= '0;
          end else if (rd_cand) begin
            arready_q <= 1'b1;
            prio_rd   <= ~prio_rd;
            timer     <= '0;
          end
        end
        W_FWD: begin
          m_axi_awvalid <= m_axi_awvalid & ~m_axi_awready;
          m_axi_wvalid  <= m_axi_wvalid & ~m_axi_wready;
          if (progress) begin
            m_axi_bready[sel_q] <= 1'b1;
            state <= W_RESP;
          end
        end
        W_RESP: if (progress) begin
          m_axi_bready <= '0;
          resp_q   <= sel_bresp;
          bvalid_q <= 1'b1;
          state    <= RESP;
        end
        R_FWD: if (progress) begin
          m_axi_arvalid <= '0;
          m_axi_rready[sel_q] <= 1'b1;
          state <= R_RESP;
        end
        R_RESP: if (progress) begin
          m_axi_rready <= '0;
          resp_q   <= sel_rresp;
          rdata_q  <= sel_rdata;
          rvalid_q <= 1'b1;
          state    <= RESP;
        end
        RESP: if ((bvalid_q && s_axi_bready) || (rvalid_q && s_axi_rready)) begin
          bvalid_q <= 1'b0;
          rvalid_q <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A hung slave is abandoned; its late response is never accepted.
      if (busy && tmo && !progress) begin
        m_axi_awvalid <= '0;  m_axi_wvalid <= '0;  m_axi_bready <= '0;
        m_axi_arvalid <= '0;  m_axi_rready <= '0;
        resp_q   <= 2'b10;
        rdata_q  <= '0;
        bvalid_q <= is_wr;
        rvalid_q <= !is_wr;
        state    <= RESP;
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_bresp   = resp_q;
  assign s_axi_rresp   = resp_q;
  assign s_axi_rdata   = rdata_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_axil_cpu_router.sv
// Directed bench for axil_cpu_router: four modelled register slaves, PS driver tasks,
// hand-computed expected responses, latencies and grant order.
module tb_axil_cpu_router;
  localparam int NS = 4, AW = 40, DW = 32;
  localparam logic [NS*AW-1:0] BASE = {40'h00_A000_0000, 40'h00_A000_2000,
                                       40'h00_A000_1000, 40'h00_A000_0000};
  localparam logic [NS*AW-1:0] MASK = {40'hFF_F000_0000, 40'hFF_FFFF_F000,
                                       40'hFF_FFFF_F000, 40'hFF_FFFF_F000};

  logic aclk = 0, aresetn = 0;
  logic [AW-1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [2:0] s_axi_awprot = '0, s_axi_arprot = '0;
  logic s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_bready = 0, s_axi_arvalid = 0, s_axi_rready = 0;
  logic [DW-1:0] s_axi_wdata = '0;
  logic [3:0] s_axi_wstrb = '0;
  logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic [DW-1:0] s_axi_rdata;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0] m_axi_awprot, m_axi_arprot, dbg_state;
  logic [DW-1:0] m_axi_wdata;
  logic [3:0] m_axi_wstrb;
  logic [NS-1:0] m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [NS-1:0] m_axi_bvalid, m_axi_rvalid;
  logic [2*NS-1:0] m_axi_bresp, m_axi_rresp;
  logic [NS*DW-1:0] m_axi_rdata;
  logic [NS-1:0] slv_rdy = '1, no_b = '0, no_r = '0;

  axil_cpu_router #(.NS(NS), .AW(AW), .DW(DW), .BASE(BASE), .MASK(MASK), .TIMEOUT(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(slv_rdy), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(slv_rdy),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(slv_rdy), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 aclk = ~aclk;

  // Slave models: accept AW/W in any order, answer one cycle after both have arrived.
  logic [1:0] b_cfg [NS], r_cfg [NS];
  logic [DW-1:0] slv_rdata [NS], cap_data [NS];
  logic [3:0] cap_strb [NS];
  logic [AW-1:0] cap_addr [NS];
  int aw_cnt [NS];
  logic [NS-1:0] got_aw, got_w;
  int m_act_cnt = 0;

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      m_axi_bresp[2*i +: 2] = b_cfg[i];
      m_axi_rresp[2*i +: 2] = r_cfg[i];
      m_axi_rdata[i*DW +: DW] = slv_rdata[i];
    end
  end

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axi_bvalid <= '0; m_axi_rvalid <= '0; got_aw <= '0; got_w <= '0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (m_axi_bvalid[i] && m_axi_bready[i]) m_axi_bvalid[i] <= 1'b0;
        if (m_axi_rvalid[i] && m_axi_rready[i]) m_axi_rvalid[i] <= 1'b0;
        if (m_axi_awvalid[i] && slv_rdy[i]) begin
          cap_addr[i] <= m_axi_awaddr;
          aw_cnt[i] <= aw_cnt[i] + 1;
        end
        if (m_axi_wvalid[i] && slv_rdy[i]) begin
          cap_data[i] <= m_axi_wdata;
          cap_strb[i] <= m_axi_wstrb;
        end
        if ((got_aw[i] || (m_axi_awvalid[i] && slv_rdy[i])) && (got_w[i] || (m_axi_wvalid[i] && slv_rdy[i]))) begin
          got_aw[i] <= 1'b0;
          got_w[i] <= 1'b0;
          if (!no_b[i]) m_axi_bvalid[i] <= 1'b1;
        end else begin
          got_aw[i] <= got_aw[i] || (m_axi_awvalid[i] && slv_rdy[i]);
          got_w[i] <= got_w[i] || (m_axi_wvalid[i] && slv_rdy[i]);
        end
        if (m_axi_arvalid[i] && slv_rdy[i] && !no_r[i]) begin
          m_axi_rvalid[i] <= 1'b1;
          slv_rdata[i] <= {8'(i), 8'h5A, m_axi_araddr[15:0]};
        end
      end
    end
  end

  always @(posedge aclk)
    if (|{m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}) m_act_cnt <= m_act_cnt + 1;

  // Grant log for the arbitration test
  logic [7:0] grant_q [$];
  bit rec_en = 0;
  always @(posedge aclk) begin
    if (rec_en && s_axi_awready && s_axi_wready) grant_q.push_back("W");
    if (rec_en && s_axi_arready) grant_q.push_back("R");
  end

  logic outs_any;
  assign outs_any = |{s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready,
                      s_axi_rdata, s_axi_rresp, s_axi_rvalid, m_axi_awaddr, m_axi_awprot,
                      m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
                      m_axi_araddr, m_axi_arprot, m_axi_arvalid, m_axi_rready, dbg_state};

  // Scoreboard counters and the single checker
  int n_vec = 0, n_err = 0;
  int last_a_k;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: k counts cycles from the one in which valid first goes high.
  task automatic ps_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] r, output int lat);
    int k;
    bit got;
    @(posedge aclk); #1;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_bready = 1;
    k = 0; got = 0; last_a_k = -1; r = 2'bxx; lat = -1;
    while (!got && k < 100) begin
      @(negedge aclk);
      if (s_axi_awready && last_a_k < 0) last_a_k = k;
      if (s_axi_bvalid) begin r = s_axi_bresp; lat = k; got = 1; end
      @(posedge aclk); #1;
      if (last_a_k >= 0) begin s_axi_awvalid = 0; s_axi_wvalid = 0; end
      k++;
    end
    s_axi_bready = 0; s_axi_awvalid = 0; s_axi_wvalid = 0;
    if (!got) check("wr_resp_wait", 0, 1);
  endtask

  task automatic ps_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] r,
                         output int lat);
    int k;
    bit got;
    @(posedge aclk); #1;
    s_axi_araddr = a; s_axi_arvalid = 1; s_axi_rready = 1;
    k = 0; got = 0; last_a_k = -1; r = 2'bxx; d = 'x; lat = -1;
    while (!got && k < 100) begin
      @(negedge aclk);
      if (s_axi_arready && last_a_k < 0) last_a_k = k;
      if (s_axi_rvalid) begin r = s_axi_rresp; d = s_axi_rdata; lat = k; got = 1; end
      @(posedge aclk); #1;
      if (last_a_k >= 0) s_axi_arvalid = 0;
      k++;
    end
    s_axi_rready = 0; s_axi_arvalid = 0;
    if (!got) check("rd_resp_wait", 0, 1);
  endtask

  task automatic reset_pulse();
    @(negedge aclk); aresetn = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1;
  endtask

  initial begin
    logic [1:0] r;
    logic [31:0] d;
    int lat, snap, others;
    bit seen, ok;
    for (int i = 0; i < NS; i++) begin
      b_cfg[i] = 2'b00; r_cfg[i] = 2'b00; aw_cnt[i] = 0;
      slv_rdata[i] = '0; cap_data[i] = '0; cap_strb[i] = '0; cap_addr[i] = '0;
    end
    #3;
    check("reset_outputs", outs_any, 0);
    repeat (3) @(negedge aclk);
    aresetn = 1;

    // Arbitration: everything held valid, grants must alternate starting with write
    @(posedge aclk); #1;
    s_axi_awaddr = 40'h00_A000_0000; s_axi_wdata = 32'h1111_2222; s_axi_wstrb = 4'hF;
    s_axi_araddr = 40'h00_A000_1004;
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1; s_axi_bready = 1; s_axi_rready = 1;
    rec_en = 1;
    repeat (60) @(posedge aclk);
    #1;
    rec_en = 0;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0; s_axi_bready = 0; s_axi_rready = 0;
    check("arb_grants_ge4", grant_q.size() >= 4, 1);
    check("arb_order", {grant_q[0], grant_q[1], grant_q[2], grant_q[3]}, "WRWR");
    reset_pulse();

    // Unmapped read: decode error two cycles after arvalid, no slave touched
    snap = m_act_cnt;
    ps_read(40'h00_B000_0000, d, r, lat);
    check("unmapped_rresp", r, 2'b11);
    check("unmapped_rdata", d, 0);
    check("unmapped_lat", lat, 2);
    check("unmapped_arready_k", last_a_k, 1);
    check("unmapped_no_slave", m_act_cnt - snap, 0);

    // 0xDEADBEEF to slave 1, one-cycle OKAY
    others = aw_cnt[0] + aw_cnt[2] + aw_cnt[3];
    ps_write(40'h00_A000_1000, 32'hDEAD_BEEF, 4'hF, r, lat);
    check("wr1_bresp", r, 2'b00);
    check("wr1_lat", lat, 4);
    check("wr1_awready_k", last_a_k, 1);
    check("wr1_slave_data", cap_data[1], 32'hDEAD_BEEF);
    check("wr1_slave_strb", cap_strb[1], 4'hF);
    check("wr1_slave_addr", cap_addr[1], 40'h00_A000_1000);
    check("wr1_others_idle", aw_cnt[0] + aw_cnt[2] + aw_cnt[3], others);

    // Slave response code propagated, and overlapping decode resolved to lowest index
    r_cfg[1] = 2'b01;
    ps_read(40'h00_A000_1008, d, r, lat);
    check("rd1_rresp", r, 2'b01);
    check("rd1_rdata", d, 32'h015A_1008);
    check("rd1_lat", lat, 4);
    r_cfg[1] = 2'b00;
    ps_read(40'h00_A000_0010, d, r, lat);
    check("rd_overlap_low", d, 32'h005A_0010);
    ps_read(40'h00_A000_5004, d, r, lat);
    check("rd3_rdata", d, 32'h035A_5004);
    check("rd3_rresp", r, 2'b00);

    // Hung slave 2: SLVERR after 8 wait cycles, then normal traffic resumes
    no_b[2] = 1;
    ps_write(40'h00_A000_2000, 32'hCAFE_0002, 4'h3, r, lat);
    check("tmo_bresp", r, 2'b10);
    check("tmo_lat", lat, 11);
    no_b[2] = 0;
    ps_read(40'h00_A000_0010, d, r, lat);
    check("after_tmo_rresp", r, 2'b00);
    check("after_tmo_rdata", d, 32'h005A_0010);

    // AW without W is never accepted
    @(posedge aclk); #1;
    s_axi_awaddr = 40'h00_A000_0040; s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'h3;
    s_axi_awvalid = 1;
    seen = 0;
    repeat (5) begin
      @(negedge aclk);
      if (s_axi_awready || s_axi_wready) seen = 1;
    end
    check("aw_alone_no_ready", seen, 0);
    @(posedge aclk); #1;
    s_axi_wvalid = 1;
    @(negedge aclk);
    check("aw_w_ready_k0", {s_axi_awready, s_axi_wready}, 2'b00);
    @(negedge aclk);
    check("aw_w_ready_k1", {s_axi_awready, s_axi_wready}, 2'b11);
    @(posedge aclk); #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 1;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge aclk);
      if (s_axi_bvalid) begin ok = 1; r = s_axi_bresp; end
    end
    @(posedge aclk); #1;
    s_axi_bready = 0;
    check("aw_w_bvalid_seen", ok, 1);
    check("aw_w_bresp", r, 2'b00);
    check("aw_w_slave_data", cap_data[0], 32'h1234_5678);
    check("aw_w_slave_strb", cap_strb[0], 4'h3);

    // Reset while waiting in R_RESP on slave 3
    no_r[3] = 1;
    @(posedge aclk); #1;
    s_axi_araddr = 40'h00_A000_7000; s_axi_arvalid = 1;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge aclk);
      if (s_axi_arready) begin @(posedge aclk); #1; s_axi_arvalid = 0; end
      if (m_axi_rready[3]) ok = 1;
    end
    check("rst_mid_reached", ok, 1);
    s_axi_arvalid = 0;
    #2 aresetn = 0;
    #1;
    check("rst_mid_outputs", outs_any, 0);
    repeat (2) @(negedge aclk);
    aresetn = 1;
    no_r[3] = 0;
    ps_read(40'h00_A000_7000, d, r, lat);
    check("post_rst_rresp", r, 2'b00);
    check("post_rst_rdata", d, 32'h035A_7000);
    check("post_rst_lat", lat, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
